serial_sub: RTL and testbench



---
 rtl/serial_sub.sv | 103 ++++++++++
 tb/tb_serial_sub.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: out = a - b - bin, one bit per clock, LSB first.
// Operands are captured on the accepting edge; out/bout update only on completion.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] out,
    output logic             bout,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] sa_reg, sb_reg, sr_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;
    logic             d, br_next, last_step;

    // One full-subtractor bit slice on the LSBs of the shifting operands.
    always_comb begin
        d         = sa_reg[0] ^ sb_reg[0] ^ br_reg;
        br_next   = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
        last_step = (cnt_reg == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_reg  <= '0;
            sb_reg  <= '0;
            sr_reg  <= '0;
            br_reg  <= 1'b0;
            cnt_reg <= '0;
            out     <= '0;
            bout    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg  <= a;
                        sb_reg  <= b;
                        br_reg  <= bin;
                        cnt_reg <= '0;
                        sr_reg  <= '0;
                    end
                end
                SHIFT: begin
                    sa_reg  <= sa_reg >> 1;
                    sb_reg  <= sb_reg >> 1;
                    sr_reg  <= {d, sr_reg[WIDTH-1:1]};
                    br_reg  <= br_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    // Results become visible only once the last bit is in.
                    if (last_step) begin
                        out  <= {d, sr_reg[WIDTH-1:1]};
                        bout <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vector table, handshake corner
// cases, reset abort and a randomized sweep against an integer reference.
module tb_serial_sub;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic [WIDTH-1:0] out;
    logic             bout, busy, done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] last_out = '0;
    logic             last_bout = 1'b0;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .out(out), .bout(bout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vbin;
        logic [WIDTH-1:0] eout;
        logic             ebout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference: plain signed integer subtraction, wrapped to WIDTH bits.
    task automatic ref_sub(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                           input logic rbin, output logic [WIDTH-1:0] rout, output logic rbout);
        int diff;
        diff  = int'(ra) - int'(rb) - int'(rbin);
        rbout = (diff < 0);
        if (diff < 0) diff = diff + (1 << WIDTH);
        rout  = diff[WIDTH-1:0];
    endtask

    // One operation. glitch: busy-cycle index at which a stray start is pulsed
    // (0 = none); start_in_done: also pulse start during the done cycle.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                          input logic obin, input logic [WIDTH-1:0] eout, input logic ebout,
                          input int glitch, input bit start_in_done);
        int  nb;
        bit  overlap, out_moved;
        @(negedge clk);
        a = oa; b = ob; bin = obin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0; overlap = 0; out_moved = 0;
        for (int k = 0; k < WIDTH + 6; k++) begin
            if (busy && done) overlap = 1;
            if (done) break;
            if (busy) nb++;
            if (out !== last_out || bout !== last_bout) out_moved = 1;
            // Operands are don't-care after acceptance; scramble them.
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            start = (glitch != 0 && nb == glitch);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_cycles"}, 32'(nb), 32'(WIDTH));
        check({tag, " out"}, 32'(out), 32'(eout));
        check({tag, " bout"}, 32'(bout), 32'(ebout));
        check({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
        check({tag, " out_stable_during_op"}, 32'(out_moved), 32'd0);
        $display("op %s: a=%0h b=%0h bin=%0d -> out=%0h bout=%0d (exp %0h/%0d) busy_cycles=%0d",
                 tag, oa, ob, obin, out, bout, eout, ebout, nb);
        last_out = eout; last_bout = ebout;
        if (start_in_done) begin
            a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_single_pulse"}, 32'(done), 32'd0);
        check({tag, " idle_after_done"}, 32'(busy), 32'd0);
        if (start_in_done) begin
            @(negedge clk);
            check({tag, " done_cycle_start_ignored"}, 32'(busy), 32'd0);
            check({tag, " out_held"}, 32'(out), 32'(eout));
        end
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        logic [WIDTH-1:0] ra, rb, eo;
        logic rbin, eb;
        int   spurious;

        vecs[0] = '{8'hAB, 8'h2E, 1'b0, 8'h7D, 1'b0};
        vecs[1] = '{8'hAB, 8'h2E, 1'b1, 8'h7C, 1'b0};
        vecs[2] = '{8'h2E, 8'hAB, 1'b0, 8'h83, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h05, 8'h07, 1'b0, 8'hFE, 1'b1};
        vecs[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
        vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[8] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

        // Reset state
        #2;
        check("reset out", 32'(out), 32'd0);
        check("reset bout", 32'(bout), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            run_op($sformatf("vec%0d", i), v.va, v.vb, v.vbin, v.eout, v.ebout, 0, 1'b0);
            @(negedge clk);
        end

        // Stray starts during SHIFT and in the DONE cycle are ignored
        run_op("ignore_start", 8'h50, 8'h10, 1'b0, 8'h40, 1'b0, 3, 1'b1);

        // Reset mid-operation aborts immediately with no done pulse
        @(negedge clk);
        a = 8'h12; b = 8'h34; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort out", 32'(out), 32'd0);
        check("abort bout", 32'(bout), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        $display("abort: rst during busy -> out=%0h bout=%0d busy=%0d done=%0d", out, bout, busy, done);
        @(negedge clk);
        rst = 1'b0;
        last_out = '0; last_bout = 1'b0;
        spurious = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        check("abort no_done", 32'(spurious), 32'd0);
        run_op("after_abort", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 0, 1'b0);

        // Randomized sweep
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
            if (i % 50 == 0) begin ra = '0; rb = '1; end
            ref_sub(ra, rb, rbin, eo, eb);
            run_op($sformatf("rnd%0d", i), ra, rb, rbin, eo, eb, 0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
